// File: rtl/cdf_hist_server.sv
// rtl/cdf_hist_server.sv - histogram scratch-memory read responder with CDF write-back (optional HIST_CLAMP_EN)
module cdf_hist_server #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 6,
    parameter int NUM_BINS  = 64,
    parameter int MEM_LAT   = 1,
    parameter int CLAMP_MAX = 4095
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read_first_value,
    input  logic              read_next_value,
    output logic              scratch_mem_read_ready,
    output logic [DATA_W-1:0] hist_value,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              cdf_computation_done,
    input  logic [DATA_W-1:0] cdf_value,
    output logic              cdf_wr_en,
    output logic [ADDR_W-1:0] cdf_wr_addr,
    output logic [DATA_W-1:0] cdf_wr_data,
    output logic              last_bin,
    output logic              req_error
`ifdef HIST_CLAMP_EN
    ,
    output logic              clamp_hit
`endif
);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ISSUE    = 2'd1;
    localparam logic [1:0] S_WAIT_MEM = 2'd2;
    localparam logic [1:0] S_PRESENT  = 2'd3;
    localparam int LAT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [DATA_W-1:0] hist_q, hist_d;
    logic              err_q, err_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              clip_q, clip_d;
    logic              at_last;
    logic              any_req;

    assign at_last = (addr_q == ADDR_W'(NUM_BINS - 1));
    assign any_req = read_first_value | read_next_value;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        mem_addr_d = mem_addr_q;
        lat_d      = lat_q;
        hist_d     = hist_q;
        err_d      = err_q;
        clip_d     = clip_q;
        case (state_q)
            S_IDLE: begin
                if (read_first_value) begin
                    addr_d     = '0;
                    mem_addr_d = '0;
                    state_d    = S_ISSUE;
                end else if (read_next_value) begin
                    if (at_last) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d     = addr_q + 1'b1;
                        mem_addr_d = addr_q + 1'b1;
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                lat_d   = LAT_W'(MEM_LAT);
                state_d = S_WAIT_MEM;
            end
            S_WAIT_MEM: begin
                if (lat_q == LAT_W'(1)) begin
`ifdef HIST_CLAMP_EN
                    if (mem_rd_data > DATA_W'(CLAMP_MAX)) begin
                        hist_d = DATA_W'(CLAMP_MAX);
                        clip_d = 1'b1;
                    end else begin
                        hist_d = mem_rd_data;
                    end
`else
                    hist_d = mem_rd_data;
`endif
                    state_d = S_PRESENT;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Any request outside IDLE is dropped and flagged.
        if (state_q != S_IDLE && any_req) begin
            err_d = 1'b1;
        end
    end

    // Write-back runs beside the read FSM and tracks the address as of the done cycle.
    always_comb begin
        wr_en_d   = cdf_computation_done;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (cdf_computation_done) begin
            wr_addr_d = addr_q;
            wr_data_d = cdf_value;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            mem_addr_q <= '0;
            lat_q      <= '0;
            hist_q     <= '0;
            err_q      <= 1'b0;
            clip_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            mem_addr_q <= mem_addr_d;
            lat_q      <= lat_d;
            hist_q     <= hist_d;
            err_q      <= err_d;
            clip_q     <= clip_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign scratch_mem_read_ready = (state_q == S_PRESENT);
    assign mem_rd_en              = (state_q == S_ISSUE);
    assign mem_addr               = mem_addr_q;
    assign hist_value             = hist_q;
    assign cdf_wr_en              = wr_en_q;
    assign cdf_wr_addr            = wr_addr_q;
    assign cdf_wr_data            = wr_data_q;
    assign last_bin               = at_last;
    assign req_error              = err_q;

`ifdef HIST_CLAMP_EN
    assign clamp_hit = clip_q;
`else
    // Clip level and flag have no role without the clamp.
    logic unused_clamp;
    assign unused_clamp = clip_q ^ (^DATA_W'(CLAMP_MAX));
`endif
endmodule

// File: doc/cdf_hist_server.md
Name: cdf_hist_server

Overview:
- Responder side of the CDF controller's scratch-memory read handshake.
- Serves one histogram bin per request from the histogram scratch SRAM.
  - `read_first_value` fetches bin 0.
  - `read_next_value` fetches the following bin.
  - Each fetched value is returned with a one-cycle `scratch_mem_read_ready` pulse.
- Also accepts the controller's `cdf_computation_done` write-back and issues the CDF SRAM write at the current bin address.

Parameters:
- DATA_W, 16, histogram/CDF word width
- ADDR_W, 6, bin address width
- NUM_BINS, 64, number of histogram bins (must be ≤ 2^ADDR_W)
- MEM_LAT, 1, scratch SRAM read latency in cycles (≥ 1)
- CLAMP_MAX, 4095, clip level (used only with HIST_CLAMP_EN)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- read_first_value  in  1  request pulse: fetch bin 0
- read_next_value  in  1  request pulse: fetch next bin
- scratch_mem_read_ready  out  1  one-cycle pulse: hist_value valid
- hist_value  out  DATA_W  fetched bin count, held until next fetch
- mem_rd_en  out  1  scratch SRAM read strobe
- mem_addr  out  ADDR_W  scratch SRAM read address
- mem_rd_data  in  DATA_W  scratch SRAM read data, valid MEM_LAT cycles after mem_rd_en
- cdf_computation_done  in  1  write-back pulse from controller
- cdf_value  in  DATA_W  CDF result, sampled with cdf_computation_done
- cdf_wr_en  out  1  CDF SRAM write strobe
- cdf_wr_addr  out  ADDR_W  CDF SRAM write address
- cdf_wr_data  out  DATA_W  CDF SRAM write data
- last_bin  out  1  high while current address == NUM_BINS-1
- req_error  out  1  sticky: request dropped (busy or past last bin)

Behaviour:
- Reset (reset=0 at a clk edge), regardless of state:
  - State returns to IDLE; the current address `addr` is cleared to 0.
  - All outputs go to 0: hist_value, mem_addr, cdf_wr_* and req_error included.
  - A fetch or write-back in flight is discarded.
- FSM states: IDLE, ISSUE, WAIT_MEM, PRESENT.
- IDLE:
  - read_first_value=1: addr←0, go to ISSUE.
  - Else read_next_value=1:
    - If addr==NUM_BINS-1: set req_error, stay IDLE, no read issued.
    - Otherwise: addr←addr+1, go to ISSUE.
  - Both requests high together: read_first_value wins.
- ISSUE: mem_rd_en=1 and mem_addr=addr for exactly one cycle; load the latency counter with MEM_LAT; go to WAIT_MEM.
- WAIT_MEM:
  - Decrement the latency counter each cycle.
  - On the cycle the counter reaches 1: capture mem_rd_data into hist_value, go to PRESENT.
- PRESENT: scratch_mem_read_ready=1 for one cycle; go to IDLE.
- Latency:
  - Request in cycle 0 → mem_rd_en in cycle 1 → ready pulse in cycle 2+MEM_LAT.
  - MEM_LAT=1 gives ready in cycle 3.
- Request while not IDLE: ignored (no addr change, no extra read); sets req_error.
- req_error is cleared only by reset.
- mem_rd_en is 0 in all states except ISSUE. mem_addr holds its last value.
- Write-back path (independent of the FSM):
  - cdf_computation_done=1 in cycle N: in cycle N+1, cdf_wr_en=1, cdf_wr_addr=addr as of cycle N, cdf_wr_data=cdf_value as of cycle N.
  - cdf_wr_en is a single-cycle pulse per done-cycle.
  - Back-to-back done pulses produce back-to-back writes.
  - A write-back coinciding with a read request is serviced in parallel.
- last_bin is combinational from addr.
- hist_value width is DATA_W.
- No arithmetic on data except the optional clamp.

Optional Feature:
- Macro HIST_CLAMP_EN.
- When defined:
  - On capture, hist_value = min(mem_rd_data, CLAMP_MAX) (unsigned compare).
  - Port clamp_hit (out, 1) is added: a sticky flag set on any clipped capture, cleared by reset.
- When undefined:
  - hist_value = mem_rd_data unmodified.
  - No clamp_hit port.
  - CLAMP_MAX is unused.

Test Plan:
- Reset low 2 cycles mid-WAIT_MEM, then high → no ready pulse; all outputs 0; next read_first_value reads addr 0.
- read_first_value pulse with MEM_LAT=1, SRAM[0]=16'd37 → mem_rd_en at cycle 1 with mem_addr=0; ready at cycle 3; hist_value=37.
- Sweep: first request, then 63 read_next requests each issued after the prior ready, SRAM[i]=i+100 → 64 ready pulses with values 100..163; last_bin=1 on the final one; then one extra read_next_value → no mem_rd_en, req_error=1.
- read_next_value re-asserted during WAIT_MEM (MEM_LAT=3) → ignored; addr unchanged; req_error=1; only one ready pulse, at cycle 5.
- cdf_computation_done with cdf_value=16'd900 while addr=5, coincident with a read_next_value → next cycle cdf_wr_en=1, cdf_wr_addr=5, cdf_wr_data=900; read proceeds to addr 6.
- HIST_CLAMP_EN defined, CLAMP_MAX=4095, SRAM[0]=16'd5000 → hist_value=4095, clamp_hit=1; with the macro undefined → hist_value=5000.
